// File: rtl/instr_fetch_decode.sv
// Front-end fetch/decode stage for the single-issue MIPS-subset core.
// Generates the PC and fetches one 32-bit word per request/valid handshake.
// The accepted word is held in the IF/ID register and split into fields.
// The sign-extension control is registered alongside the instruction word.
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm,
    output logic        id_extend_sign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // PC values are always word aligned; the low two address bits are dropped here.
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALN  = RESET_PC & PC_ALIGN_MASK;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic        free_s;
    logic        accept_s;

    logic        id_valid_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_instr_r;
    logic        id_extend_sign_r;

    // Only signed-immediate opcodes may request ones-fill, and only when imm[15] is set.
    // The downstream extender fills with ones unconditionally when asked.
    function automatic logic needs_sign_fill(input logic [31:0] instr);
        logic fill;
        case (instr[31:26])
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h20, 6'h23, 6'h28, 6'h2B: fill = instr[15];
            default:                           fill = 1'b0;
        endcase
        return fill;
    endfunction

    // State register: reset parks the FSM in IDLE for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: redirect always lands in FETCH, regardless of stall.
    always_comb begin
        state_s = state_r;
        if (redirect) begin
            state_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = ST_FETCH;
                ST_FETCH: state_s = free_s ? ST_FETCH : ST_HOLD;
                ST_HOLD:  state_s = stall ? ST_HOLD : ST_FETCH;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Output logic: request only while fetching into a slot that frees up this cycle.
    always_comb begin
        free_s    = !id_valid_r || !stall;
        imem_addr = pc_r;
        case (state_r)
            ST_FETCH: imem_req = free_s;
            default:  imem_req = 1'b0;
        endcase
        accept_s = imem_req && imem_valid && !redirect;
    end

    // PC and IF/ID register: redirect flushes, accept captures, a consumed slot empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r             <= RESET_PC_ALN;
            id_valid_r       <= 1'b0;
            id_pc_r          <= 32'h0000_0000;
            id_instr_r       <= 32'h0000_0000;
            id_extend_sign_r <= 1'b0;
        end else if (redirect) begin
            pc_r             <= redirect_pc & PC_ALIGN_MASK;
            id_valid_r       <= 1'b0;
            id_pc_r          <= id_pc_r;
            id_instr_r       <= id_instr_r;
            id_extend_sign_r <= id_extend_sign_r;
        end else if (accept_s) begin
            pc_r             <= pc_r + 32'd4;
            id_valid_r       <= 1'b1;
            id_pc_r          <= pc_r;
            id_instr_r       <= imem_rdata;
            id_extend_sign_r <= needs_sign_fill(imem_rdata);
        end else if (free_s) begin
            pc_r             <= pc_r;
            id_valid_r       <= 1'b0;
            id_pc_r          <= id_pc_r;
            id_instr_r       <= id_instr_r;
            id_extend_sign_r <= id_extend_sign_r;
        end else begin
            pc_r             <= pc_r;
            id_valid_r       <= id_valid_r;
            id_pc_r          <= id_pc_r;
            id_instr_r       <= id_instr_r;
            id_extend_sign_r <= id_extend_sign_r;
        end
    end

    assign id_valid       = id_valid_r;
    assign id_pc          = id_pc_r;
    assign id_instr       = id_instr_r;
    assign id_opcode      = id_instr_r[31:26];
    assign id_rs          = id_instr_r[25:21];
    assign id_rt          = id_instr_r[20:16];
    assign id_rd          = id_instr_r[15:11];
    assign id_imm         = id_instr_r[15:0];
    assign id_extend_sign = id_extend_sign_r;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: the stimulus side plays instruction memory
// and queues the expected IF/ID contents; the monitor pops whenever downstream consumes.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_valid, stall, redirect;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, id_valid, id_extend_sign;
    logic [31:0] imem_addr, id_pc, id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;

    logic        w_valid, w_req, w_id_valid, w_id_ext;
    logic [31:0] w_rdata, w_addr, w_id_pc, w_id_instr;
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm;

    instr_fetch_decode #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_extend_sign(id_extend_sign)
    );

    instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_valid(w_valid), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0000_0000), .id_valid(w_id_valid),
        .id_pc(w_id_pc), .id_instr(w_id_instr), .id_opcode(w_opcode), .id_rs(w_rs),
        .id_rt(w_rt), .id_rd(w_rd), .id_imm(w_imm), .id_extend_sign(w_id_ext)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ext;
        logic [31:0] sext;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Present one word at addr; optionally wait 'delay' cycles with imem_valid low first.
    // Called and returns at posedge+1.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input logic ext,
                         input logic [31:0] sext, input int delay, input bit b2b);
        int   waited;
        exp_t e;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, addr);
            @(posedge clk); #1;
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        waited     = 0;
        forever begin
            @(negedge clk);
            if (imem_req) break;
            waited++;
            if (waited > 20) break;
            @(posedge clk); #1;
        end
        if (waited > 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_timeout addr=%h actual=no_req required=req", addr);
        end else begin
            chk("fetch_addr", imem_addr, addr);
            if (b2b) chk("back_to_back", 32'(waited), 32'd0);
            e.pc = addr; e.instr = instr; e.ext = ext; e.sext = sext;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        imem_valid = 1'b0;
    endtask

    // Monitor: an instruction leaves IF/ID when consumed (!stall) or flushed (redirect).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && id_valid && (!stall || redirect)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr actual=%h required=none", id_instr);
            end else begin
                e = exp_q.pop_front();
                chk("id_pc", id_pc, e.pc);
                chk("id_instr", id_instr, e.instr);
                chk("id_opcode", 32'(id_opcode), 32'(e.instr[31:26]));
                chk("id_regs", {17'd0, id_rs, id_rt, id_rd}, {17'd0, e.instr[25:11]});
                chk("id_imm", 32'(id_imm), 32'(e.instr[15:0]));
                chk("id_extend_sign", 32'(id_extend_sign), 32'(e.ext));
                chk("sign_extend_out", {{16{id_extend_sign}}, id_imm}, e.sext);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        ext;
        logic [31:0] sext;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h0000_0100, 32'h2008_FFFC, 1'b1, 32'hFFFF_FFFC}; // addi neg
        vecs[1]  = '{32'h0000_0104, 32'h3508_FFFC, 1'b0, 32'h0000_FFFC}; // ori
        vecs[2]  = '{32'h0000_0108, 32'h2008_0004, 1'b0, 32'h0000_0004}; // addi pos
        vecs[3]  = '{32'h0000_010C, 32'h8C22_FFF0, 1'b1, 32'hFFFF_FFF0}; // lw
        vecs[4]  = '{32'h0000_0110, 32'h0022_8020, 1'b0, 32'h0000_8020}; // R-type
        vecs[5]  = '{32'h0000_0114, 32'h3C01_8000, 1'b0, 32'h0000_8000}; // lui
        vecs[6]  = '{32'h0000_0118, 32'h1022_FFFF, 1'b1, 32'hFFFF_FFFF}; // beq
        vecs[7]  = '{32'h0000_011C, 32'h3022_8000, 1'b0, 32'h0000_8000}; // andi
        vecs[8]  = '{32'h0000_0120, 32'hAC22_8004, 1'b1, 32'hFFFF_8004}; // sw
        vecs[9]  = '{32'h0000_0124, 32'h0800_8000, 1'b0, 32'h0000_8000}; // j
        vecs[10] = '{32'h0000_0128, 32'h2822_FFFF, 1'b1, 32'hFFFF_FFFF}; // slti
        vecs[11] = '{32'h0000_012C, 32'h1422_8000, 1'b1, 32'hFFFF_8000}; // bne

        rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; w_valid = 1'b0; w_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, observed in the IDLE cycle
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_ext", 32'(id_extend_sign), 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_0100);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;

        // Back-to-back fetches with decode of several opcode classes
        for (int i = 0; i < 12; i++)
            fetch(vecs[i].addr, vecs[i].instr, vecs[i].ext, vecs[i].sext, 0, i > 0);

        // Stall for three cycles with a valid instruction held
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_id_valid", 32'(id_valid), 32'd1);
            chk("stall_id_pc", id_pc, 32'h0000_012C);
            chk("stall_id_instr", id_instr, 32'h1422_8000);
            chk("stall_pc", imem_addr, 32'h0000_0130);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        fetch(32'h0000_0130, 32'h2128_0001, 1'b0, 32'h0000_0001, 0, 1'b0);

        // Redirect while stalled with a coincident response word
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0203;
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("redir_stall_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        stall = 1'b0; redirect = 1'b0; imem_valid = 1'b0;
        @(negedge clk);
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h0000_0200);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_no_discard", id_instr, 32'h2128_0001);
        @(posedge clk); #1;
        fetch(32'h0000_0200, 32'h8D09_0010, 1'b0, 32'h0000_0010, 0, 1'b1);

        // Redirect while a request is being answered: the word is dropped
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        imem_valid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("redir2_req", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        redirect = 1'b0; imem_valid = 1'b0;
        @(negedge clk);
        chk("redir2_id_valid", 32'(id_valid), 32'd0);
        chk("redir2_addr", imem_addr, 32'h0000_0300);
        @(posedge clk); #1;

        // Slow memory: response after four idle cycles
        fetch(32'h0000_0300, 32'h2D0A_8001, 1'b1, 32'hFFFF_8001, 4, 1'b0);

        // Reset in the middle of a wait, with a coincident response
        repeat (2) begin
            @(negedge clk);
            chk("rstwait_req", 32'(imem_req), 32'd1);
            chk("rstwait_addr", imem_addr, 32'h0000_0304);
            @(posedge clk); #1;
        end
        rst_n = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hBADC_0DE0;
        @(posedge clk); #1;
        rst_n = 1'b1; imem_valid = 1'b0;
        @(negedge clk);
        chk("rst2_req", 32'(imem_req), 32'd0);
        chk("rst2_id_valid", 32'(id_valid), 32'd0);
        chk("rst2_addr", imem_addr, 32'h0000_0100);
        chk("rst2_id_instr", id_instr, 32'h0);
        @(posedge clk); #1;
        fetch(32'h0000_0100, 32'h2408_0005, 1'b0, 32'h0000_0005, 0, 1'b1);

        // PC wrap on the second instance
        w_valid = 1'b1; w_rdata = 32'h2008_FFFC;
        @(negedge clk);
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        w_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        chk("wrap_id_valid", 32'(w_id_valid), 32'd1);
        chk("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_ext", 32'(w_id_ext), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
